// File: rtl/w5500_pkg.sv
`default_nettype none
// ============================================================================
// Module      : w5500_pkg
// Description : Shared FSM encoding, control-byte layout and timing constants
//               for the W5500-style SPI slave.
// Revision    : 1.0 - initial release
// ============================================================================
package w5500_pkg;

  localparam int c_state_w = 3;

  localparam logic [c_state_w-1:0] c_st_idle = 3'd0;
  localparam logic [c_state_w-1:0] c_st_addr = 3'd1;
  localparam logic [c_state_w-1:0] c_st_ctrl = 3'd2;
  localparam logic [c_state_w-1:0] c_st_data = 3'd3;
  localparam logic [c_state_w-1:0] c_st_done = 3'd4;

  // Control byte layout: BSB[7:3], RWB[2], OM[1:0]
  localparam int c_bsb_msb = 7;
  localparam int c_bsb_lsb = 3;
  localparam int c_rwb_bit = 2;
  localparam int c_om_msb  = 1;
  localparam int c_om_lsb  = 0;

  localparam logic       c_rwb_write = 1'b1;
  localparam logic [1:0] c_om_var    = 2'b00;
  localparam logic [1:0] c_om_1b     = 2'b01;
  localparam logic [1:0] c_om_2b     = 2'b10;
  localparam logic [1:0] c_om_4b     = 2'b11;

  // Clocks from o_rd_req to the cycle in which rd_dat is captured
  localparam int c_rd_latency = 2;

  function automatic logic [2:0] om_len(input logic [1:0] om);
    logic [2:0] len;
    case (om)
      c_om_1b: len = 3'd1;
      c_om_2b: len = 3'd2;
      c_om_4b: len = 3'd4;
      default: len = 3'd0;
    endcase
    return len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/w5500_spi_sync.sv
`default_nettype none
// ============================================================================
// Module      : w5500_spi_sync
// Description : SYNC_STAGES-deep synchronizers for CS/SCK/MOSI plus CS and
//               SCK edge detection in the clk domain.
// Revision    : 1.0 - initial release
// ============================================================================
module w5500_spi_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_spi_cs,
  input  logic i_spi_sck,
  input  logic i_spi_mosi,
  output logic o_cs_s,
  output logic o_cs_fall,
  output logic o_cs_rise,
  output logic o_sck_rise,
  output logic o_sck_fall,
  output logic o_mosi_s
);

  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_cs_d;
  logic                   r_sck_d;

  // CS resets low so a CS already low at reset release never looks like a
  // fall; a real high phase must be seen first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs_sync   <= '0;
      r_sck_sync  <= '0;
      r_mosi_sync <= '0;
      r_cs_d      <= 1'b0;
      r_sck_d     <= 1'b0;
    end else begin
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_spi_cs};
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], i_spi_sck};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
      r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
      r_sck_d     <= r_sck_sync[SYNC_STAGES-1];
    end
  end

  assign o_cs_s     = r_cs_sync[SYNC_STAGES-1];
  assign o_cs_fall  = r_cs_d & ~r_cs_sync[SYNC_STAGES-1];
  assign o_cs_rise  = ~r_cs_d & r_cs_sync[SYNC_STAGES-1];
  assign o_sck_rise = ~r_sck_d & r_sck_sync[SYNC_STAGES-1];
  assign o_sck_fall = r_sck_d & ~r_sck_sync[SYNC_STAGES-1];
  assign o_mosi_s   = r_mosi_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/w5500_spi_slave.sv
`default_nettype none
// ============================================================================
// Module      : w5500_spi_slave
// Description : W5500-framed SPI mode-0 slave: address/control decode, byte
//               write strobes and prefetched read data on MISO.
//               Option macro: W5500_SLV_FIXED_LEN_EN (OM-selected length).
// Revision    : 1.0 - initial release
// ============================================================================
module w5500_spi_slave
  import w5500_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_cs,
  input  logic        spi_sck,
  input  logic        spi_mosi,
  output logic        o_spi_miso,
  output logic        o_spi_miso_oe,
  output logic        o_wr_vld,
  output logic        o_rd_req,
  output logic [4:0]  o_bsb,
  output logic [15:0] o_addr,
  output logic [7:0]  o_wr_dat,
  input  logic [7:0]  rd_dat,
  output logic        o_frm_end,
  output logic        o_frm_err
);

  logic w_cs_s, w_cs_fall, w_cs_rise, w_sck_rise, w_sck_fall, w_mosi_s;

  logic [c_state_w-1:0]    r_state;
  logic [c_state_w-1:0]    w_next_state;
  logic [2:0]              r_bit_cnt;
  logic                    r_addr_lo;
  logic [6:0]              r_shift_in;
  logic [7:0]              r_shift_out;
  logic                    r_rwb;
  logic [c_rd_latency-1:0] r_rd_pipe;
  logic                    r_armed;
  logic                    r_miso_oe;
  logic                    r_wr_vld;
  logic                    r_rd_req;
  logic                    r_frm_end;
  logic                    r_frm_err;
  logic [4:0]              r_bsb;
  logic [15:0]             r_addr;
  logic [7:0]              r_wr_dat;

  logic [7:0] w_byte;
  logic       w_in_frame;
  logic       w_byte_done;
  logic       w_miso_en;
  logic       w_shift_out;
  logic       w_last_byte;

  w5500_spi_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_spi_cs   (spi_cs),
    .i_spi_sck  (spi_sck),
    .i_spi_mosi (spi_mosi),
    .o_cs_s     (w_cs_s),
    .o_cs_fall  (w_cs_fall),
    .o_cs_rise  (w_cs_rise),
    .o_sck_rise (w_sck_rise),
    .o_sck_fall (w_sck_fall),
    .o_mosi_s   (w_mosi_s)
  );

  assign w_byte = {r_shift_in, w_mosi_s};

`ifdef W5500_SLV_FIXED_LEN_EN
  logic [1:0] r_om;
  logic [2:0] r_dat_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_om      <= c_om_var;
      r_dat_cnt <= 3'd0;
    end else if (w_cs_fall) begin
      r_dat_cnt <= 3'd0;
    end else if (w_byte_done && (r_state == c_st_ctrl)) begin
      r_om <= w_byte[c_om_msb:c_om_lsb];
    end else if (w_byte_done && (r_state == c_st_data)) begin
      r_dat_cnt <= r_dat_cnt + 3'd1;
    end
  end

  assign w_last_byte = (r_om != c_om_var) && ((r_dat_cnt + 3'd1) == om_len(r_om));
`else
  assign w_last_byte = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_st_idle;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    if (w_cs_rise) begin
      w_next_state = c_st_idle;
    end else begin
      case (r_state)
        c_st_idle: if (w_cs_fall)                 w_next_state = c_st_addr;
        c_st_addr: if (w_byte_done && r_addr_lo)  w_next_state = c_st_ctrl;
        c_st_ctrl: if (w_byte_done)               w_next_state = c_st_data;
        c_st_data: if (w_byte_done && w_last_byte) w_next_state = c_st_done;
        c_st_done: w_next_state = c_st_done;
        default:   w_next_state = c_st_idle;
      endcase
    end
  end

  // State-decoded controls
  always_comb begin
    w_in_frame  = (r_state != c_st_idle);
    w_byte_done = w_in_frame && w_sck_rise && (r_bit_cnt == 3'd7);
    w_miso_en   = (r_state == c_st_data) && (r_rwb != c_rwb_write);
    // The fall right after a byte boundary keeps bit 7 of the freshly loaded byte
    w_shift_out = w_miso_en && w_sck_fall && (r_bit_cnt != 3'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt   <= 3'd0;
      r_addr_lo   <= 1'b0;
      r_shift_in  <= 7'd0;
      r_shift_out <= 8'd0;
      r_rwb       <= 1'b0;
      r_rd_pipe   <= '0;
      r_armed     <= 1'b0;
      r_miso_oe   <= 1'b0;
      r_wr_vld    <= 1'b0;
      r_rd_req    <= 1'b0;
      r_frm_end   <= 1'b0;
      r_frm_err   <= 1'b0;
      r_bsb       <= 5'd0;
      r_addr      <= 16'd0;
      r_wr_dat    <= 8'd0;
    end else begin
      r_wr_vld  <= 1'b0;
      r_rd_req  <= 1'b0;
      r_frm_end <= 1'b0;
      r_frm_err <= 1'b0;
      if (w_cs_s) r_armed <= 1'b1;
      r_miso_oe <= r_armed & ~w_cs_s;
      r_rd_pipe <= {r_rd_pipe[c_rd_latency-2:0], r_rd_req};

      if (w_cs_fall) begin
        r_bit_cnt <= 3'd0;
        r_addr_lo <= 1'b0;
      end else if (w_in_frame && w_sck_rise) begin
        r_bit_cnt  <= r_bit_cnt + 3'd1;
        r_shift_in <= w_byte[6:0];
      end

      if (w_cs_rise && w_in_frame) begin
        r_frm_end <= 1'b1;
        r_frm_err <= (r_bit_cnt != 3'd0);
      end

      // Write address advances the cycle after its strobe so the strobe sees it
      if (r_wr_vld) r_addr <= r_addr + 16'd1;

      if (w_byte_done && !w_cs_rise) begin
        case (r_state)
          c_st_addr: begin
            if (!r_addr_lo) begin
              r_addr[15:8] <= w_byte;
              r_addr_lo    <= 1'b1;
            end else begin
              r_addr[7:0] <= w_byte;
            end
          end
          c_st_ctrl: begin
            r_bsb <= w_byte[c_bsb_msb:c_bsb_lsb];
            r_rwb <= w_byte[c_rwb_bit];
            if (w_byte[c_rwb_bit] != c_rwb_write) r_rd_req <= 1'b1;
          end
          c_st_data: begin
            if (r_rwb == c_rwb_write) begin
              r_wr_vld <= 1'b1;
              r_wr_dat <= w_byte;
            end else begin
              r_addr <= r_addr + 16'd1;
              if (!w_last_byte) r_rd_req <= 1'b1;
            end
          end
          default: ;
        endcase
      end

      if (r_rd_pipe[c_rd_latency-1])
        r_shift_out <= rd_dat;
      else if (w_shift_out)
        r_shift_out <= {r_shift_out[6:0], 1'b0};
    end
  end

  assign o_spi_miso    = r_shift_out[7] & w_miso_en;
  assign o_spi_miso_oe = r_miso_oe;
  assign o_wr_vld      = r_wr_vld;
  assign o_rd_req      = r_rd_req;
  assign o_bsb         = r_bsb;
  assign o_addr        = r_addr;
  assign o_wr_dat      = r_wr_dat;
  assign o_frm_end     = r_frm_end;
  assign o_frm_err     = r_frm_err;

endmodule
`default_nettype wire

// File: tb/tb_w5500_spi_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_w5500_spi_slave
// Description : Directed self-checking bench for w5500_spi_slave.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_w5500_spi_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_cs = 1'b1;
  logic        spi_sck = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        o_spi_miso, o_spi_miso_oe, o_wr_vld, o_rd_req, o_frm_end, o_frm_err;
  logic [4:0]  o_bsb;
  logic [15:0] o_addr;
  logic [7:0]  o_wr_dat;
  logic [7:0]  rd_dat = 8'h00;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] wr_addr_q[$];
  logic [7:0]  wr_dat_q[$];
  logic [4:0]  wr_bsb_q[$];
  logic [15:0] rd_addr_q[$];
  logic [4:0]  rd_bsb_q[$];
  int          fe_n = 0;
  int          ferr_n = 0;
  int          stray_err = 0;
  int          rd_idx = 0;
  logic [7:0]  rd_src [0:3] = '{8'h04, 8'h05, 8'h00, 8'h00};

  always #5 clk = ~clk;

  w5500_spi_slave #(.SYNC_STAGES(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .spi_cs        (spi_cs),
    .spi_sck       (spi_sck),
    .spi_mosi      (spi_mosi),
    .o_spi_miso    (o_spi_miso),
    .o_spi_miso_oe (o_spi_miso_oe),
    .o_wr_vld      (o_wr_vld),
    .o_rd_req      (o_rd_req),
    .o_bsb         (o_bsb),
    .o_addr        (o_addr),
    .o_wr_dat      (o_wr_dat),
    .rd_dat        (rd_dat),
    .o_frm_end     (o_frm_end),
    .o_frm_err     (o_frm_err)
  );

  // Event logger and read-data responder
  always @(negedge clk) begin
    if (o_wr_vld) begin
      wr_addr_q.push_back(o_addr);
      wr_dat_q.push_back(o_wr_dat);
      wr_bsb_q.push_back(o_bsb);
    end
    if (o_rd_req) begin
      rd_addr_q.push_back(o_addr);
      rd_bsb_q.push_back(o_bsb);
      if (rd_idx < 4) rd_dat = rd_src[rd_idx];
      rd_idx++;
    end
    if (o_frm_end) fe_n++;
    if (o_frm_err) ferr_n++;
    if (o_frm_err && !o_frm_end) stray_err++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = tx[i];
      #80;
      rx[i] = o_spi_miso;
      spi_sck = 1'b1;
      #80;
      spi_sck = 1'b0;
    end
  endtask

  task automatic cs_low();
    @(negedge clk);
    spi_cs = 1'b0;
    #160;
  endtask

  task automatic cs_high();
    #160;
    spi_cs = 1'b1;
    #300;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_miso"},   32'(o_spi_miso),    32'h0);
    check({tag, "_oe"},     32'(o_spi_miso_oe), 32'h0);
    check({tag, "_wr_vld"}, 32'(o_wr_vld),      32'h0);
    check({tag, "_rd_req"}, 32'(o_rd_req),      32'h0);
    check({tag, "_fend"},   32'(o_frm_end),     32'h0);
    check({tag, "_ferr"},   32'(o_frm_err),     32'h0);
    check({tag, "_bsb"},    32'(o_bsb),         32'h0);
    check({tag, "_addr"},   32'(o_addr),        32'h0);
    check({tag, "_wdat"},   32'(o_wr_dat),      32'h0);
  endtask

  initial begin
    logic [7:0] rx, rx0, rx1, rx_or;
    int wb, rb, fb, eb, exp_n;

    repeat (4) @(negedge clk);
    check_all_zero("rst");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Write frame: addr 0x0010, ctrl 0x04, data AA 55
    wb = wr_addr_q.size(); fb = fe_n; eb = ferr_n;
    cs_low();
    spi_xfer(8'h00, 8, rx);
    spi_xfer(8'h10, 8, rx);
    check("wr_oe", 32'(o_spi_miso_oe), 32'h1);
    spi_xfer(8'h04, 8, rx);
    spi_xfer(8'hAA, 8, rx0);
    spi_xfer(8'h55, 8, rx1);
    check("wr_miso", 32'(rx0 | rx1), 32'h0);
    cs_high();
    check("wr_cnt",   32'(wr_addr_q.size() - wb), 32'd2);
    check("wr_addr0", 32'(wr_addr_q[wb]),     32'h0010);
    check("wr_dat0",  32'(wr_dat_q[wb]),      32'hAA);
    check("wr_addr1", 32'(wr_addr_q[wb + 1]), 32'h0011);
    check("wr_dat1",  32'(wr_dat_q[wb + 1]),  32'h55);
    check("wr_bsb",   32'(wr_bsb_q[wb]),      32'h00);
    check("wr_fend",  32'(fe_n - fb),   32'd1);
    check("wr_ferr",  32'(ferr_n - eb), 32'd0);
    check("idle_oe",  32'(o_spi_miso_oe), 32'h0);

    // Read frame: addr 0x0039, ctrl 0x08, responder returns 04 then 05
    rb = rd_addr_q.size(); fb = fe_n; eb = ferr_n;
    cs_low();
    spi_xfer(8'h00, 8, rx_or);
    spi_xfer(8'h39, 8, rx);
    rx_or = rx_or | rx;
    spi_xfer(8'h08, 8, rx);
    rx_or = rx_or | rx;
    check("rd_hdr_miso", 32'(rx_or), 32'h0);
    spi_xfer(8'h00, 8, rx0);
    spi_xfer(8'h00, 8, rx1);
    cs_high();
    check("rd_byte0", 32'(rx0), 32'h04);
    check("rd_byte1", 32'(rx1), 32'h05);
    check("rd_req_cnt", 32'(rd_addr_q.size() - rb), 32'd3);
    check("rd_addr0", 32'(rd_addr_q[rb]),     32'h0039);
    check("rd_addr1", 32'(rd_addr_q[rb + 1]), 32'h003A);
    check("rd_bsb",   32'(rd_bsb_q[rb]),      32'h01);
    check("rd_fend",  32'(fe_n - fb),   32'd1);
    check("rd_ferr",  32'(ferr_n - eb), 32'd0);

    // Address wrap: 3 writes from 0xFFFF
    wb = wr_addr_q.size();
    cs_low();
    spi_xfer(8'hFF, 8, rx);
    spi_xfer(8'hFF, 8, rx);
    spi_xfer(8'h04, 8, rx);
    spi_xfer(8'h11, 8, rx);
    spi_xfer(8'h22, 8, rx);
    spi_xfer(8'h33, 8, rx);
    cs_high();
    check("wrap_cnt",   32'(wr_addr_q.size() - wb), 32'd3);
    check("wrap_addr0", 32'(wr_addr_q[wb]),     32'hFFFF);
    check("wrap_addr1", 32'(wr_addr_q[wb + 1]), 32'h0000);
    check("wrap_addr2", 32'(wr_addr_q[wb + 2]), 32'h0001);
    check("wrap_dat2",  32'(wr_dat_q[wb + 2]),  32'h33);

    // OM=10 write with 4 data bytes
`ifdef W5500_SLV_FIXED_LEN_EN
    exp_n = 2;
`else
    exp_n = 4;
`endif
    wb = wr_addr_q.size(); eb = ferr_n;
    cs_low();
    spi_xfer(8'h01, 8, rx);
    spi_xfer(8'h00, 8, rx);
    spi_xfer(8'h06, 8, rx);
    spi_xfer(8'hC1, 8, rx);
    spi_xfer(8'hC2, 8, rx);
    spi_xfer(8'hC3, 8, rx0);
    spi_xfer(8'hC4, 8, rx1);
    cs_high();
    check("om_cnt",   32'(wr_addr_q.size() - wb), 32'(exp_n));
    check("om_addr1", 32'(wr_addr_q[wb + 1]), 32'h0101);
    check("om_miso",  32'(rx0 | rx1), 32'h0);
    check("om_ferr",  32'(ferr_n - eb), 32'd0);

    // CS rise after 5 bits of the 2nd data byte
    wb = wr_addr_q.size(); fb = fe_n; eb = ferr_n;
    cs_low();
    spi_xfer(8'h00, 8, rx);
    spi_xfer(8'h20, 8, rx);
    spi_xfer(8'h04, 8, rx);
    spi_xfer(8'h12, 8, rx);
    spi_xfer(8'hFF, 5, rx);
    cs_high();
    check("part_cnt",  32'(wr_addr_q.size() - wb), 32'd1);
    check("part_dat",  32'(wr_dat_q[wb]), 32'h12);
    check("part_fend", 32'(fe_n - fb),   32'd1);
    check("part_ferr", 32'(ferr_n - eb), 32'd1);
    check("stray_err", 32'(stray_err),   32'd0);

    // Reset mid-ADDR, then a fresh frame after CS toggles
    wb = wr_addr_q.size(); fb = fe_n;
    cs_low();
    spi_xfer(8'hA5, 5, rx);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("mid_rst");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_oe", 32'(o_spi_miso_oe), 32'h0);
    spi_cs = 1'b1;
    #300;
    check("post_rst_fend", 32'(fe_n - fb), 32'd0);
    cs_low();
    spi_xfer(8'h00, 8, rx);
    spi_xfer(8'h42, 8, rx);
    spi_xfer(8'h0C, 8, rx);
    spi_xfer(8'h5A, 8, rx);
    cs_high();
    check("rec_cnt",  32'(wr_addr_q.size() - wb), 32'd1);
    check("rec_addr", 32'(wr_addr_q[wb]), 32'h0042);
    check("rec_dat",  32'(wr_dat_q[wb]),  32'h5A);
    check("rec_bsb",  32'(wr_bsb_q[wb]),  32'h01);
    check("rec_fend", 32'(fe_n - fb), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/w5500_spi_slave.md
W5500_SPI_SLAVE -- requirements
Module: w5500_spi_slave

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth applied to spi_cs, spi_sck and spi_mosi; legal range is 2..3.
REQ-002 clk  input  1  system clock; shall be at least 8x the SPI clock frequency.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 spi_cs  input  1  chip select, active-low, asynchronous to clk.
REQ-005 spi_sck  input  1  SPI clock in mode 0 (idle low), asynchronous to clk.
REQ-006 spi_mosi  input  1  serial data from the master, MSB first.
REQ-007 o_spi_miso  output  1  serial data to the master, MSB first.
REQ-008 o_spi_miso_oe  output  1  MISO drive enable; high while the synchronized CS is low.
REQ-009 o_wr_vld  output  1  one-clk pulse per received write data byte.
REQ-010 o_rd_req  output  1  one-clk pulse requesting one read byte.
REQ-011 o_bsb  output  5  block select field of the current frame.
REQ-012 o_addr  output  16  byte address of the current write or read.
REQ-013 o_wr_dat  output  8  write byte; valid while o_wr_vld is high.
REQ-014 rd_dat  input  8  read byte; sampled exactly 2 clk after o_rd_req.
REQ-015 o_frm_end  output  1  one-clk pulse on CS deassertion when a frame was in progress.
REQ-016 o_frm_err  output  1  one-clk pulse, coincident with o_frm_end, when CS rose with a partial byte pending.

Function
REQ-017 The block shall edge-detect the synchronized SCK, sample MOSI on rising edges and update MISO on falling edges.
REQ-018 The frame format shall be: 16-bit address, then an 8-bit control byte (BSB[7:3], RWB[2] with 1 = write, OM[1:0]), then the data phase.
REQ-019 The FSM states shall be IDLE, ADDR, CTRL, DATA and DONE.
REQ-020 FSM transitions:
- CS fall: IDLE->ADDR.
- ADDR->CTRL after 16 bits.
- CTRL->DATA after 8 bits.
- DATA->DONE when the fixed length is exhausted.
- CS rise: any state->IDLE.
REQ-021 A 3-bit bit counter shall be cleared on every CS fall.
REQ-022 On a write, o_wr_vld shall pulse 1 clk after the rising edge of each 8th data bit, with o_addr and o_bsb valid in the same cycle.
REQ-023 On a read, o_rd_req shall pulse 1 clk after the last CTRL bit and 1 clk after the rising edge of each 8th data bit.
REQ-024 The read byte shall be loaded into the shift register before the next SCK falling edge, and bit 7 shall be driven first.
REQ-025 o_addr shall increment by 1 after each completed data byte and wrap from 0xFFFF to 0x0000.
REQ-026 o_spi_miso shall be 0 in the IDLE, ADDR, CTRL and DONE states and during write frames.
REQ-027 On CS rise mid-byte, the partial byte shall be discarded with no o_wr_vld, and o_frm_err shall pulse.
REQ-028 SCK edges while CS is high shall be ignored.
REQ-029 A CS fall in the same clk as the o_frm_end of the previous frame shall start a new frame normally.

Reset
REQ-030 While rst_n is low, the FSM shall be IDLE, all counters 0, and o_spi_miso, o_spi_miso_oe, o_wr_vld, o_rd_req, o_frm_end, o_frm_err, o_bsb, o_addr and o_wr_dat all 0.
REQ-031 Reset asserted mid-frame shall abort the frame with no pulses; after release, the block shall wait for CS high before accepting a new CS fall.

Configuration
REQ-032 The macro W5500_SLV_FIXED_LEN_EN shall control fixed-length operation.
- Defined: OM 01/10/11 selects 1/2/4 data bytes, then DONE until CS rise; OM 00 is variable length.
- Undefined: OM is ignored, every frame is variable length, and the DONE state is unreachable.

Structure
REQ-033 A shared package w5500_pkg shall hold the FSM state encoding, the control-byte field positions, the RWB/OM encodings and the read latency constant (2).
REQ-034 There shall be one sub-module, w5500_spi_sync, containing the SYNC_STAGES synchronizers and the SCK rise/fall edge detection.

Verification
REQ-035 Write frame: addr 0x0010, ctrl 0x04 (BSB 0, write, OM 00), data 0xAA, 0x55 -> o_wr_vld twice with (0x0010, 0xAA) then (0x0011, 0x55), followed by o_frm_end without o_frm_err.
REQ-036 Read frame: addr 0x0039, ctrl 0x08 (BSB 1, read), bench returns 0x04 then 0x05 -> MISO bytes 0x04, 0x05; o_rd_req addresses 0x0039, 0x003A.
REQ-037 Wrap: write of 3 bytes starting at addr 0xFFFF -> o_addr sequence 0xFFFF, 0x0000, 0x0001.
REQ-038 With the macro defined, write ctrl 0x06 (OM 10) followed by 4 data bytes -> exactly 2 o_wr_vld pulses and MISO 0 afterwards; without the macro -> 4 pulses.
REQ-039 CS rise after 5 bits of the 2nd data byte -> 1 o_wr_vld pulse, then o_frm_end with o_frm_err.
REQ-040 rst_n asserted mid-ADDR phase -> all outputs 0; a subsequent valid frame after CS toggles high then low completes correctly.
